seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial bit-pattern detector. Successor to the fixed "0110" detector. Pattern, length and bit mask are loadable at run time, and detection can be overlapping or non-overlapping. Input bits carry a valid qualifier, and a saturating match counter runs alongside the pulse output. The block sits directly on a serial bit stream and drives a registered one-cycle match pulse to downstream control logic.

## Interface
Parameters:
- MAX_LEN, 8, maximum pattern length in bits (≥2)
- CNT_W, 16, match counter width
- DEF_PATTERN, 8'b0000_0110, pattern loaded at reset (LSB-aligned)
- DEF_LEN, 4, pattern length loaded at reset

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- i  in  1  serial data bit
- i_valid  in  1  i is sampled only when high
- cfg_load  in  1  latch cfg_pattern/cfg_mask/cfg_len/cfg_overlap
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
- cfg_mask  in  MAX_LEN  1 = compare this bit, 0 = don't care
- cfg_len  in  $clog2(MAX_LEN+1)  active length; 0 disables detection; values >MAX_LEN are clamped to MAX_LEN
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping
- cnt_clr  in  1  clear match counter
- o  out  1  match pulse
- armed  out  1  window holds ≥len valid bits since the last restart
- match_cnt  out  CNT_W  saturating count of matches

## Operation
- The window register win[MAX_LEN-1:0] shifts on valid input: win ← {win[MAX_LEN-2:0], i} when i_valid.
- Fill counter fill (0..MAX_LEN) increments on each valid bit and saturates at MAX_LEN.
- FSM states:
  - IDLE: len==0. o is never asserted.
  - FILL: fill_next < len.
  - ARMED: fill_next ≥ len.
  - Transitions: IDLE→FILL on a cfg_load with nonzero len. FILL→ARMED when a valid bit brings fill to len. ARMED→FILL on a non-overlap match or a cfg_load. Any state→IDLE on a cfg_load with len 0.
- Match condition, evaluated only on a valid-bit cycle in ARMED (including the bit that enters ARMED): ((win_next ^ pattern) & mask & lenmask) == 0, where lenmask has ones in bits [len-1:0]. An all-zero effective mask therefore matches on every valid bit once armed.
- Overlap mode: after a match, fill stays saturated, so the next match may reuse bits.
- Non-overlap mode: after a match, fill is reset to 0 and the state returns to FILL.
- cfg_load:
  - New configuration is active from the next cycle.
  - fill is cleared and win is kept.
  - A valid bit presented in the same cycle is discarded, with no shift and no match.
- match_cnt increments on each match and saturates at 2^CNT_W−1. cnt_clr in the same cycle as a match takes priority: match_cnt becomes 0.
- Reset values:
  - o=0, armed=0, match_cnt=0, win=0, fill=0.
  - pattern=DEF_PATTERN, len=DEF_LEN, mask=all ones, overlap=1.
  - State is FILL, or IDLE if DEF_LEN==0.

## Timing
- o is registered. It is high for exactly one cycle, the cycle after the edge that samples the completing bit. Latency is 1 clock from the last pattern bit.
- match_cnt updates on the same edge that raises o.
- armed is registered and reflects the state after the current edge.
- i_valid low: win, fill and state hold, and o is 0 the following cycle.
- Reset mid-pattern: partial window content is discarded and detection restarts from empty. A pattern straddling the reset never matches.
- Back-to-back matches in overlap mode can produce o high on consecutive cycles (for example pattern 11, input 111).

## Structure
- Package seq_detector_pkg holds:
  - the state enum (IDLE, FILL, ARMED)
  - the LEN_W width constant
  - the lenmask function
- Sub-module seq_match_counter holds the saturating counter with clear priority (parameter CNT_W; inputs inc and clr).
- The top level holds the configuration registers, the window, fill, the FSM and the compare logic.

## Test plan
- Default config, overlap, stream 0,1,1,0,1,1,0 all valid → o pulses after bit 4 and after bit 7; match_cnt=2.
- Same stream after cfg_load with cfg_overlap=0 (pattern 0110, len 4, mask 1111) → single pulse after bit 4; match_cnt increments by 1.
- cfg_pattern=8'b1001, cfg_mask=8'b1011, len 4, stream 1,1,0,1 → pulse (bit 2 don't care); stream 0,1,0,1 → no pulse.
- Pattern 0110 with i_valid low for 3 cycles between each bit → one pulse, one cycle after the 4th valid bit; no pulses during gaps.
- rst asserted after 0,1,1, then bits 0 → no pulse, armed=0; then 0,1,1,0 → pulse.
- CNT_W=2, pattern 11 len 2 overlap, nine 1s → match_cnt saturates at 3; cnt_clr coincident with a match → match_cnt=0.

Source files
------------

// File: rtl/seq_detector_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
//   state_e       : detector FSM states
//   MAX_LEN_LIMIT : largest MAX_LEN the helpers support
//   LEN_W         : internal width for length/fill arithmetic
//   lenmask()     : ones in bits [len-1:0]
package seq_detector_pkg;

  localparam int unsigned MAX_LEN_LIMIT = 32;
  localparam int unsigned LEN_W = $clog2(MAX_LEN_LIMIT + 1);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StArmed
  } state_e;

  function automatic logic [MAX_LEN_LIMIT-1:0] lenmask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN_LIMIT-1:0] m;
    for (int unsigned k = 0; k < MAX_LEN_LIMIT; k++) begin
      m[k] = (k < 32'(len));
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter; clear wins over increment.
//   clk, rst : clock, synchronous active-high reset
//   inc      : count one match
//   clr      : force count to zero
//   cnt      : current count, sticks at all ones
module seq_match_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Run-time configurable serial bit-pattern detector with valid qualifier,
// overlapping/non-overlapping modes and a saturating match counter.
//   clk, rst    : clock, synchronous active-high reset
//   i, i_valid  : serial data bit and its qualifier
//   cfg_*       : pattern/mask/length/overlap, latched on cfg_load
//   cnt_clr     : clear match counter (wins over a coincident match)
//   o           : registered one-cycle match pulse
//   armed       : enough valid bits held to compare
//   match_cnt   : saturating match count
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter int unsigned         MAX_LEN     = 8,
  parameter int unsigned         CNT_W       = 16,
  parameter logic [MAX_LEN-1:0]  DEF_PATTERN = MAX_LEN'(8'b0000_0110),
  parameter int unsigned         DEF_LEN     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i,
  input  logic                         i_valid,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [MAX_LEN-1:0]           cfg_mask,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         cnt_clr,
  output logic                         o,
  output logic                         armed,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam logic [LEN_W-1:0] MaxLen   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DefLen   = (DEF_LEN > MAX_LEN) ? MaxLen : LEN_W'(DEF_LEN);
  localparam state_e           DefState = (DEF_LEN == 0) ? StIdle : StFill;

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [MAX_LEN-1:0] mask_q, mask_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  // The oldest window bit is never compared again once it shifts out, so only
  // MAX_LEN-1 bits of history are stored; win_next is the full window.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  state_e             state_q, state_d;
  logic               o_q, armed_q;

  logic [MAX_LEN-1:0] win_next;
  logic [MAX_LEN-1:0] lm;
  logic [LEN_W-1:0]   cfg_len_ext, cfg_len_clamp, fill_inc;
  logic               hit, match;

  assign cfg_len_ext   = LEN_W'(cfg_len);
  assign cfg_len_clamp = (cfg_len_ext > MaxLen) ? MaxLen : cfg_len_ext;
  assign win_next      = {hist_q, i};
  assign lm            = MAX_LEN'(lenmask(len_q));
  assign hit           = (((win_next ^ pattern_q) & mask_q & lm) == '0);
  assign fill_inc      = (fill_q == MaxLen) ? fill_q : fill_q + LEN_W'(1);

  always_comb begin
    pattern_d = pattern_q;
    mask_d    = mask_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    state_d   = state_q;
    match     = 1'b0;
    if (cfg_load) begin
      // Any data bit in a load cycle is dropped; window content is kept.
      pattern_d = cfg_pattern;
      mask_d    = cfg_mask;
      len_d     = cfg_len_clamp;
      overlap_d = cfg_overlap;
      fill_d    = '0;
      state_d   = (cfg_len_clamp == '0) ? StIdle : StFill;
    end else if (i_valid) begin
      hist_d = win_next[MAX_LEN-2:0];
      fill_d = fill_inc;
      unique case (state_q)
        StIdle: state_d = StIdle;
        StFill, StArmed: begin
          if (fill_inc >= len_q) begin
            state_d = StArmed;
            if (hit) begin
              match = 1'b1;
              if (!overlap_q) begin
                fill_d  = '0;
                state_d = StFill;
              end
            end
          end else begin
            state_d = StFill;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= DEF_PATTERN;
      mask_q    <= '1;
      len_q     <= DefLen;
      overlap_q <= 1'b1;
      hist_q    <= '0;
      fill_q    <= '0;
      state_q   <= DefState;
      o_q       <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      o_q       <= match;
      armed_q   <= (state_d == StArmed);
    end
  end

  seq_match_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(match),
    .clr(cnt_clr),
    .cnt(match_cnt)
  );

  assign o     = o_q;
  assign armed = armed_q;

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        a_i, a_valid, a_load, a_ovl, a_clr, a_o, a_armed;
  logic [7:0]  a_pat, a_mask;
  logic [3:0]  a_len;
  logic [15:0] a_cnt;

  // Instance B: 2-bit counter for saturation
  logic        b_i, b_valid, b_load, b_ovl, b_clr, b_o, b_armed;
  logic [7:0]  b_pat, b_mask;
  logic [3:0]  b_len;
  logic [1:0]  b_cnt;

  int errors = 0;
  int checks = 0;

  seq_detector_param u_a (
    .clk(clk), .rst(rst), .i(a_i), .i_valid(a_valid), .cfg_load(a_load),
    .cfg_pattern(a_pat), .cfg_mask(a_mask), .cfg_len(a_len), .cfg_overlap(a_ovl),
    .cnt_clr(a_clr), .o(a_o), .armed(a_armed), .match_cnt(a_cnt)
  );

  seq_detector_param #(.CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .i(b_i), .i_valid(b_valid), .cfg_load(b_load),
    .cfg_pattern(b_pat), .cfg_mask(b_mask), .cfg_len(b_len), .cfg_overlap(b_ovl),
    .cnt_clr(b_clr), .o(b_o), .armed(b_armed), .match_cnt(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_a(input logic b);
    a_i = b; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic idle_a();
    a_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load_a(input logic [7:0] pat, input logic [7:0] msk, input logic [3:0] len,
                        input logic ovl, input logic v, input logic d);
    a_pat = pat; a_mask = msk; a_len = len; a_ovl = ovl;
    a_load = 1'b1; a_valid = v; a_i = d;
    @(posedge clk); #1;
    a_load = 1'b0; a_valid = 1'b0;
  endtask

  // Bits and expected pulses are listed first-bit-first (MSB of the n-bit field).
  task automatic run_a(input logic [15:0] bits, input logic [15:0] exp_o, input int n,
                       input string tag);
    for (int k = n - 1; k >= 0; k--) begin
      send_a(bits[k]);
      check($sformatf("%s_o[%0d]", tag, n - 1 - k), 32'(a_o), 32'(exp_o[k]));
    end
  endtask

  task automatic send_b(input logic b);
    b_i = b; b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_i = 0; a_valid = 0; a_load = 0; a_pat = 0; a_mask = 0; a_len = 0; a_ovl = 0; a_clr = 0;
    b_i = 0; b_valid = 0; b_load = 0; b_pat = 0; b_mask = 0; b_len = 0; b_ovl = 0; b_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o", 32'(a_o), 0);
    check("rst_armed", 32'(a_armed), 0);
    check("rst_cnt", 32'(a_cnt), 0);
    check("rst_b_cnt", 32'(b_cnt), 0);
    rst = 1'b0;

    // Default config (0110, len 4, overlap): pulses after bits 4 and 7
    run_a(16'b0110110, 16'b0001001, 7, "ovl");
    check("ovl_cnt", 32'(a_cnt), 2);
    check("ovl_armed", 32'(a_armed), 1);
    idle_a();
    check("gap_o", 32'(a_o), 0);

    // Non-overlap; the valid bit in the load cycle is dropped
    load_a(8'b0110, 8'hff, 4'd4, 1'b0, 1'b1, 1'b1);
    check("load_o", 32'(a_o), 0);
    check("load_armed", 32'(a_armed), 0);
    run_a(16'b0110110, 16'b0001000, 7, "novl");
    check("novl_cnt", 32'(a_cnt), 3);
    check("novl_armed", 32'(a_armed), 0);

    // Masked compare: bit 2 is don't care
    load_a(8'b1001, 8'b1011, 4'd4, 1'b1, 1'b0, 1'b0);
    run_a(16'b1101_0101, 16'b0001_0000, 8, "mask");
    check("mask_cnt", 32'(a_cnt), 4);

    // Three invalid cycles between pattern bits
    load_a(8'b0110, 8'hff, 4'd4, 1'b1, 1'b0, 1'b0);
    for (int k = 3; k >= 0; k--) begin
      send_a(k == 2 || k == 1);
      check($sformatf("vgap_bit%0d_o", 3 - k), 32'(a_o), 32'(k == 0));
      for (int g = 0; g < 3; g++) begin
        idle_a();
        check($sformatf("vgap_idle%0d_o", 3 - k), 32'(a_o), 0);
      end
    end
    check("vgap_cnt", 32'(a_cnt), 5);

    // Reset mid-pattern discards the partial window
    run_a(16'b011, 16'b000, 3, "prerst");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_armed", 32'(a_armed), 0);
    check("midrst_cnt", 32'(a_cnt), 0);
    run_a(16'b0, 16'b0, 1, "postrst");
    check("postrst_armed", 32'(a_armed), 0);
    run_a(16'b0110, 16'b0001, 4, "rstpat");
    check("rstpat_cnt", 32'(a_cnt), 1);

    // Length 0 disables detection
    load_a(8'b0110, 8'hff, 4'd0, 1'b1, 1'b0, 1'b0);
    run_a(16'b0110_0110, 16'b0, 8, "len0");
    check("len0_armed", 32'(a_armed), 0);
    check("len0_cnt", 32'(a_cnt), 1);

    // Length above MAX_LEN clamps to 8
    load_a(8'hA5, 8'hff, 4'd15, 1'b1, 1'b0, 1'b0);
    run_a(16'hA5, 16'h01, 8, "clamp");
    check("clamp_armed", 32'(a_armed), 1);
    check("clamp_cnt", 32'(a_cnt), 2);

    // CNT_W=2: pattern 11 overlap, nine 1s -> back-to-back pulses, saturate at 3
    b_pat = 8'b11; b_mask = 8'hff; b_len = 4'd2; b_ovl = 1'b1; b_load = 1'b1;
    @(posedge clk); #1;
    b_load = 1'b0;
    for (int k = 0; k < 9; k++) begin
      send_b(1'b1);
      check($sformatf("sat_o[%0d]", k), 32'(b_o), 32'(k >= 1));
    end
    check("sat_cnt", 32'(b_cnt), 3);
    b_clr = 1'b1;
    send_b(1'b1);
    check("clr_o", 32'(b_o), 1);
    check("clr_cnt", 32'(b_cnt), 0);
    b_clr = 1'b0;
    send_b(1'b1);
    check("afterclr_cnt", 32'(b_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
